// File: rtl/exc_pkg.sv
// Shared definitions for the exception controller: state encoding,
// syndrome codes and default parameters.
package exc_pkg;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_FLUSH   = 3'd1,
        ST_HANDLER = 3'd2,
        ST_RETURN  = 3'd3,
        ST_HALT    = 3'd4
    } state_e;

    localparam logic [3:0] ESR_NONE = 4'b0000;
    localparam logic [3:0] ESR_INV  = 4'b0001;
    localparam logic [3:0] ESR_IRQ  = 4'b0010;
    localparam logic [3:0] ESR_ERET = 4'b0011;

    localparam logic [63:0] DEF_VECTOR_ADDR  = 64'h0000_0000_0000_00D8;
    localparam int          DEF_FLUSH_CYCLES = 2;

endpackage

// File: rtl/exception_ctrl_if.sv
// Decode-stage view plus PC-mux/pipeline controls exchanged between the
// core pipeline (master) and the exception controller (slave).
interface exception_ctrl_if;

    logic        InstrValid_D;
    logic        NotAnInstr_D;
    logic        ERet_D;
    logic [63:0] PC_D;
    logic        ExtIRQ;

    logic        Exc;
    logic [63:0] ExcVector;
    logic        EretTaken;
    logic        Flush;
    logic [63:0] ELR;
    logic [3:0]  ESR;
    logic        IrqAck;
    logic        InHandler;
    logic        Halt;

    modport master (
        output InstrValid_D, NotAnInstr_D, ERet_D, PC_D, ExtIRQ,
        input  Exc, ExcVector, EretTaken, Flush, ELR, ESR,
        input  IrqAck, InHandler, Halt
    );

    modport slave (
        input  InstrValid_D, NotAnInstr_D, ERet_D, PC_D, ExtIRQ,
        output Exc, ExcVector, EretTaken, Flush, ELR, ESR,
        output IrqAck, InHandler, Halt
    );

endinterface

// File: rtl/exception_ctrl.sv
// Exception/interrupt controller: detects faults, IRQs and stray ERETs,
// flushes the front of the pipeline and tracks the handler lifecycle.
module exception_ctrl
    import exc_pkg::*;
#(
    parameter logic [63:0] VECTOR_ADDR  = DEF_VECTOR_ADDR,
    parameter int          FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
    input logic             clk,
    input logic             reset,
    exception_ctrl_if.slave bus
);

    localparam logic [2:0] CNT_INIT    = 3'(FLUSH_CYCLES - 1);
    localparam state_e     FLUSH_ENTRY = (FLUSH_CYCLES > 1) ? ST_FLUSH
                                                             : ST_HANDLER;

    state_e      r_state;
    state_e      w_next;
    logic [2:0]  r_cnt;
    logic [63:0] r_elr;
    logic [3:0]  r_esr;

    logic        w_inv;
    logic        w_eret;
    logic        w_event;
    logic        w_take;
    logic [3:0]  w_code;

    logic        w_exc;
    logic        w_eret_tk;
    logic        w_ack;
    logic        w_flush;
    logic        w_halt;
    logic        w_inh;

    assign w_inv   = bus.InstrValid_D & bus.NotAnInstr_D;
    assign w_eret  = bus.InstrValid_D & bus.ERet_D;
    assign w_event = w_inv | w_eret | bus.ExtIRQ;
    assign w_take  = (r_state == ST_RUN) & w_event;

    always_comb begin
        w_code = ESR_IRQ;
        if (w_inv)       w_code = ESR_INV;
        else if (w_eret) w_code = ESR_ERET;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_RUN: begin
                if (w_event) w_next = FLUSH_ENTRY;
            end
            ST_FLUSH: begin
                if (r_cnt <= 3'd1) w_next = ST_HANDLER;
            end
            ST_HANDLER: begin
                if (w_inv)       w_next = ST_HALT;
                else if (w_eret) w_next = ST_RETURN;
            end
            ST_RETURN: w_next = ST_RUN;
            ST_HALT:   w_next = ST_HALT;
            default:   w_next = ST_RUN;
        endcase
    end

    // Outputs are forced low while reset is held, whatever the inputs do.
    always_comb begin
        w_exc     = 1'b0;
        w_eret_tk = 1'b0;
        w_ack     = 1'b0;
        w_flush   = 1'b0;
        w_halt    = 1'b0;
        w_inh     = 1'b0;
        if (reset) begin
            unique case (r_state)
                ST_RUN: begin
                    w_exc   = w_event;
                    w_flush = w_event;
                    w_ack   = bus.ExtIRQ & ~w_inv & ~w_eret;
                end
                ST_FLUSH: begin
                    w_flush = 1'b1;
                    w_inh   = 1'b1;
                end
                ST_HANDLER: begin
                    w_inh     = 1'b1;
                    w_eret_tk = w_eret & ~w_inv;
                    w_flush   = w_eret & ~w_inv;
                end
                ST_RETURN: begin
                    w_flush = 1'b1;
                end
                ST_HALT: begin
                    w_halt  = 1'b1;
                    w_flush = 1'b1;
                end
                default: begin
                    w_flush = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= 3'd0;
        end else if (w_take) begin
            r_cnt <= CNT_INIT;
        end else if (r_state == ST_FLUSH) begin
            r_cnt <= r_cnt - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_elr <= 64'd0;
            r_esr <= ESR_NONE;
        end else if (w_take) begin
            r_elr <= bus.PC_D;
            r_esr <= w_code;
        end
    end

    assign bus.Exc       = w_exc;
    assign bus.ExcVector = VECTOR_ADDR;
    assign bus.EretTaken = w_eret_tk;
    assign bus.IrqAck    = w_ack;
    assign bus.Flush     = w_flush;
    assign bus.Halt      = w_halt;
    assign bus.InHandler = w_inh;
    assign bus.ELR       = r_elr;
    assign bus.ESR       = r_esr;

endmodule

// File: tb/tb_exception_ctrl.sv
// Bench for exception_ctrl: directed vector table, corner sequences and
// random traffic on two instances (FLUSH_CYCLES=2 and 1).
module tb_exception_ctrl;

    typedef struct {
        int          fl;
        bit          inh;
        bit          ret;
        bit          halt;
        logic [63:0] elr;
        logic [3:0]  esr;
    } m_t;

    typedef struct {
        bit exc;
        bit eret;
        bit ack;
        bit flush;
        bit halt;
        bit inh;
    } o_t;

    typedef struct {
        bit          iv, na, er, irq;
        logic [63:0] pc;
        o_t          o;
        logic [63:0] elr;
        logic [3:0]  esr;
    } vec_t;

    localparam logic [63:0] VEC = 64'h0000_0000_0000_00D8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    m_t   ma, mb;

    exception_ctrl_if ifa ();
    exception_ctrl_if ifb ();

    exception_ctrl #(.FLUSH_CYCLES(2)) u_a (
        .clk(clk), .reset(rst_n), .bus(ifa)
    );
    exception_ctrl #(.FLUSH_CYCLES(1)) u_b (
        .clk(clk), .reset(rst_n), .bus(ifb)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic o_t m_out(m_t m, bit iv, bit na, bit er, bit irq);
        o_t o = '{default: 1'b0};
        if (m.halt) begin
            o.halt  = 1'b1;
            o.flush = 1'b1;
        end else if (m.ret) begin
            o.flush = 1'b1;
        end else if (m.inh) begin
            o.inh = 1'b1;
            if (m.fl > 0) begin
                o.flush = 1'b1;
            end else begin
                o.eret  = iv & er & ~na;
                o.flush = o.eret;
            end
        end else begin
            o.exc   = (iv & na) | (iv & er) | irq;
            o.flush = o.exc;
            o.ack   = irq & ~(iv & na) & ~(iv & er);
        end
        return o;
    endfunction

    function automatic m_t m_next(m_t m, int fc, bit iv, bit na, bit er,
                                  bit irq, logic [63:0] pc);
        m_t n = m;
        if (m.halt) begin
            n = m;
        end else if (m.ret) begin
            n.ret = 1'b0;
        end else if (m.inh) begin
            if (m.fl > 0) n.fl = m.fl - 1;
            else if (iv & na) begin
                n.inh  = 1'b0;
                n.halt = 1'b1;
            end else if (iv & er) begin
                n.inh = 1'b0;
                n.ret = 1'b1;
            end
        end else if ((iv & na) | (iv & er) | irq) begin
            n.elr = pc;
            n.esr = (iv & na) ? 4'd1 : (iv & er) ? 4'd3 : 4'd2;
            n.fl  = fc - 1;
            n.inh = 1'b1;
        end
        return n;
    endfunction

    function automatic m_t m_reset();
        m_t m;
        m.fl = 0; m.inh = 0; m.ret = 0; m.halt = 0;
        m.elr = 64'd0; m.esr = 4'd0;
        return m;
    endfunction

    task automatic drive(bit iv, bit na, bit er, bit irq, logic [63:0] pc);
        ifa.InstrValid_D = iv; ifa.NotAnInstr_D = na; ifa.ERet_D = er;
        ifa.ExtIRQ = irq; ifa.PC_D = pc;
        ifb.InstrValid_D = iv; ifb.NotAnInstr_D = na; ifb.ERet_D = er;
        ifb.ExtIRQ = irq; ifb.PC_D = pc;
    endtask

    task automatic cmp_a(string t, o_t e, logic [63:0] elr, logic [3:0] esr);
        chk({t, ".Exc"},       64'(ifa.Exc),       64'(e.exc));
        chk({t, ".EretTaken"}, 64'(ifa.EretTaken), 64'(e.eret));
        chk({t, ".IrqAck"},    64'(ifa.IrqAck),    64'(e.ack));
        chk({t, ".Flush"},     64'(ifa.Flush),     64'(e.flush));
        chk({t, ".Halt"},      64'(ifa.Halt),      64'(e.halt));
        chk({t, ".InHandler"}, 64'(ifa.InHandler), 64'(e.inh));
        chk({t, ".ELR"},       ifa.ELR,            elr);
        chk({t, ".ESR"},       64'(ifa.ESR),       64'(esr));
    endtask

    task automatic cmp_b(string t, o_t e, logic [63:0] elr, logic [3:0] esr);
        chk({t, ".Exc"},       64'(ifb.Exc),       64'(e.exc));
        chk({t, ".EretTaken"}, 64'(ifb.EretTaken), 64'(e.eret));
        chk({t, ".IrqAck"},    64'(ifb.IrqAck),    64'(e.ack));
        chk({t, ".Flush"},     64'(ifb.Flush),     64'(e.flush));
        chk({t, ".Halt"},      64'(ifb.Halt),      64'(e.halt));
        chk({t, ".InHandler"}, 64'(ifb.InHandler), 64'(e.inh));
        chk({t, ".ELR"},       ifb.ELR,            elr);
        chk({t, ".ESR"},       64'(ifb.ESR),       64'(esr));
    endtask

    // One clock: drive after the edge, check mid-cycle, advance the model.
    task automatic step(bit iv, bit na, bit er, bit irq, logic [63:0] pc);
        @(posedge clk);
        #1 drive(iv, na, er, irq, pc);
        #2;
        cmp_a("a", m_out(ma, iv, na, er, irq), ma.elr, ma.esr);
        cmp_b("b", m_out(mb, iv, na, er, irq), mb.elr, mb.esr);
        chk("ExcVector", ifa.ExcVector, VEC);
        ma = m_next(ma, 2, iv, na, er, irq, pc);
        mb = m_next(mb, 1, iv, na, er, irq, pc);
    endtask

    task automatic do_reset();
        o_t z = '{default: 1'b0};
        @(posedge clk);
        #1 rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 64'hdead);
        #2;
        cmp_a("rst_a", z, 64'd0, 4'd0);
        cmp_b("rst_b", z, 64'd0, 4'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
        #2;
        cmp_a("rel_a", z, 64'd0, 4'd0);
        ma = m_reset();
        mb = m_reset();
    endtask

    function automatic vec_t mk(bit iv, bit na, bit er, bit irq,
                                logic [63:0] pc, bit exc, bit eret, bit ack,
                                bit fl, bit hlt, bit inh,
                                logic [63:0] elr, logic [3:0] esr);
        vec_t v;
        v.iv = iv; v.na = na; v.er = er; v.irq = irq; v.pc = pc;
        v.o = '{exc, eret, ack, fl, hlt, inh};
        v.elr = elr; v.esr = esr;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        ma = m_reset();
        mb = m_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
        //          iv na er irq pc        exc er ak fl ht ih elr     esr
        tbl.push_back(mk(0, 0, 0, 0, 64'h0,   0, 0, 0, 0, 0, 0, 64'h0,   0));
        tbl.push_back(mk(1, 1, 0, 0, 64'h40,  1, 0, 0, 1, 0, 0, 64'h0,   0));
        tbl.push_back(mk(0, 0, 0, 1, 64'h44,  0, 0, 0, 1, 0, 1, 64'h40,  1));
        tbl.push_back(mk(0, 0, 0, 1, 64'h48,  0, 0, 0, 0, 0, 1, 64'h40,  1));
        tbl.push_back(mk(1, 0, 1, 0, 64'h4c,  0, 1, 0, 1, 0, 1, 64'h40,  1));
        tbl.push_back(mk(0, 0, 0, 1, 64'h50,  0, 0, 0, 1, 0, 0, 64'h40,  1));
        tbl.push_back(mk(0, 0, 0, 1, 64'h100, 1, 0, 1, 1, 0, 0, 64'h40,  1));
        tbl.push_back(mk(0, 0, 0, 0, 64'h104, 0, 0, 0, 1, 0, 1, 64'h100, 2));
        tbl.push_back(mk(1, 1, 1, 1, 64'h108, 0, 0, 0, 0, 0, 1, 64'h100, 2));
        tbl.push_back(mk(0, 0, 0, 1, 64'h10c, 0, 0, 0, 1, 1, 0, 64'h100, 2));
        tbl.push_back(mk(1, 1, 0, 1, 64'h110, 0, 0, 0, 1, 1, 0, 64'h100, 2));

        do_reset();
        foreach (tbl[i]) begin
            step(tbl[i].iv, tbl[i].na, tbl[i].er, tbl[i].irq, tbl[i].pc);
            cmp_a($sformatf("tbl%0d", i), tbl[i].o, tbl[i].elr, tbl[i].esr);
        end

        // Halt is left only through reset, which clears the syndrome.
        do_reset();
        step(0, 0, 0, 0, 64'h0);
        chk("halt_cleared", 64'(ifa.Halt), 64'd0);

        // Invalid opcode outranks a simultaneous IRQ; IRQ is taken after return.
        step(1, 1, 0, 1, 64'h200);
        chk("prio_ack", 64'(ifa.IrqAck), 64'd0);
        step(0, 0, 0, 1, 64'h204);
        chk("prio_esr", 64'(ifa.ESR), 64'd1);
        step(1, 0, 1, 1, 64'h208);
        step(0, 0, 0, 1, 64'h20c);
        step(0, 0, 0, 1, 64'h300);
        chk("irq_ack", 64'(ifa.IrqAck), 64'd1);
        step(0, 0, 0, 0, 64'h304);
        chk("irq_esr", 64'(ifa.ESR), 64'd2);
        chk("irq_elr", ifa.ELR, 64'h300);
        step(0, 0, 0, 0, 64'h0);
        step(1, 0, 1, 0, 64'h0);
        step(0, 0, 0, 0, 64'h0);

        // Stray ERET in RUN; unqualified opcode flag is ignored.
        step(0, 1, 0, 0, 64'h7c);
        chk("bubble_noexc", 64'(ifa.Exc), 64'd0);
        step(1, 0, 1, 0, 64'h80);
        step(0, 0, 0, 0, 64'h84);
        chk("eret_esr", 64'(ifa.ESR), 64'd3);
        chk("eret_elr", ifa.ELR, 64'h80);

        // Reset in the middle of a flush abandons it.
        do_reset();
        step(1, 1, 0, 0, 64'h500);
        do_reset();
        step(0, 0, 0, 0, 64'h0);
        chk("midflush_flush", 64'(ifa.Flush), 64'd0);

        for (int i = 0; i < 3000; i++) begin
            bit iv, na, er, irq;
            iv  = ($urandom_range(0, 1) == 1);
            na  = ($urandom_range(0, 7) == 0);
            er  = ($urandom_range(0, 5) == 0);
            irq = ($urandom_range(0, 5) == 0);
            if ((ma.halt && mb.halt && $urandom_range(0, 9) == 0) ||
                $urandom_range(0, 199) == 0)
                do_reset();
            step(iv, na, er, irq, {$urandom, $urandom});
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/exception_ctrl.md
EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 Parameter VECTOR_ADDR, default 64'h0000_0000_0000_00D8, meaning: exception handler entry address driven on ExcVector.
REQ-002 Parameter FLUSH_CYCLES, default 2, range 1..7, meaning: number of cycles Flush is held after an exception is taken.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 InstrValid_D  input  1  decode-stage instruction is real (not a bubble); qualifies NotAnInstr_D and ERet_D.
REQ-006 NotAnInstr_D  input  1  decoder flags an invalid opcode.
REQ-007 ERet_D  input  1  decoder flags ERET.
REQ-008 PC_D  input  64  address of the decode-stage instruction.
REQ-009 ExtIRQ  input  1  external interrupt request, level-sensitive.
REQ-010 Exc  output  1  one-cycle pulse: PC mux selects ExcVector.
REQ-011 ExcVector  output  64  constant VECTOR_ADDR.
REQ-012 EretTaken  output  1  one-cycle pulse: PC mux selects ELR.
REQ-013 Flush  output  1  squash IF/ID and ID/EX pipeline registers.
REQ-014 ELR  output  64  exception link register (return address).
REQ-015 ESR  output  4  exception syndrome: 4'b0000 none, 4'b0001 invalid opcode, 4'b0010 external IRQ, 4'b0011 ERET outside handler.
REQ-016 IrqAck  output  1  one-cycle pulse acknowledging a taken IRQ.
REQ-017 InHandler  output  1  high in FLUSH and HANDLER states.
REQ-018 Halt  output  1  double fault; core stops fetching.

Function
REQ-019 States: RUN, FLUSH, HANDLER, RETURN, HALT; encoding fixed by the shared package.
REQ-020 Exception event in RUN: (InstrValid_D & NotAnInstr_D) or (InstrValid_D & ERet_D) or ExtIRQ.
REQ-021 Priority within one cycle: invalid opcode > ERET-outside-handler > ExtIRQ; exactly one event is taken.
REQ-022 On event in RUN: same cycle Exc=1, Flush=1; next edge ELR<=PC_D, ESR<=code, count<=FLUSH_CYCLES-1, state<=FLUSH.
REQ-023 IrqAck=1 in the same cycle as Exc only when the taken event is ExtIRQ.
REQ-024 FLUSH: Flush=1; count decrements each cycle; at count==0 next state HANDLER; FLUSH_CYCLES=1 goes directly to HANDLER after the detect cycle.
REQ-025 All decode inputs and ExtIRQ are ignored in FLUSH (interrupts masked).
REQ-026 HANDLER: ExtIRQ masked; InstrValid_D & ERet_D -> same cycle EretTaken=1, Flush=1; next state RETURN.
REQ-027 HANDLER: InstrValid_D & NotAnInstr_D (takes priority over ERet_D) -> next state HALT; ELR/ESR unchanged.
REQ-028 RETURN: Flush=1 for exactly one cycle, all inputs ignored, next state RUN; ExtIRQ still high is taken no earlier than the first RUN cycle.
REQ-029 HALT: Halt=1, Flush=1, all inputs ignored; exit only by reset.
REQ-030 ELR and ESR hold until the next taken exception; ERET does not clear them.
REQ-031 InHandler=1 in FLUSH and HANDLER; 0 in RUN, RETURN, HALT.
REQ-032 Exc, EretTaken, IrqAck are combinational from state and inputs; ELR, ESR, state, count are registered.

Reset
REQ-033 reset low asynchronously forces state RUN, ELR=0, ESR=4'b0000, count=0.
REQ-034 During reset: Exc=EretTaken=IrqAck=Flush=Halt=InHandler=0.
REQ-035 Reset asserted mid-FLUSH, HANDLER or HALT abandons the sequence; no pulse is emitted on the release cycle.

Structure
REQ-036 Package exc_pkg holds the state enum, ESR code constants and the default VECTOR_ADDR.
REQ-037 Single module, no sub-module; the flush counter is 3 bits, inline.

Verification
REQ-038 RUN, PC_D=64'h40, InstrValid_D=1, NotAnInstr_D=1 -> Exc=1, Flush=1 that cycle; ELR=64'h40, ESR=4'b0001; Flush high 2 cycles total; then InHandler=1 in HANDLER.
REQ-039 RUN, ExtIRQ=1 and NotAnInstr_D=1 same cycle -> ESR=4'b0001, IrqAck=0; after ERET and RETURN, IRQ still high -> taken with ESR=4'b0010, IrqAck=1.
REQ-040 HANDLER, ERet_D=1 with ELR=64'h40 -> EretTaken=1 and Flush=1 that cycle, one RETURN cycle with Flush=1, then RUN; ELR stays 64'h40.
REQ-041 HANDLER, NotAnInstr_D=1 -> Halt=1 from next cycle, persistent; ExtIRQ ignored; reset low -> RUN, Halt=0, ESR=0.
REQ-042 RUN, ERet_D=1, InstrValid_D=1, PC_D=64'h80 -> Exc=1, ESR=4'b0011, ELR=64'h80; InstrValid_D=0 with NotAnInstr_D=1 -> no exception.
